// File: rtl/bullet_flight_app_pkg.sv
// Shared tank-game definitions: grid defaults, direction codes and bullet FSM encodings.
package bullet_flight_app_pkg;

  localparam int unsigned XMaxDef = 24;
  localparam int unsigned YMaxDef = 12;
  localparam int unsigned CoordW  = 5;

  typedef enum logic [1:0] {
    DirUp    = 2'b00,
    DirDown  = 2'b01,
    DirLeft  = 2'b10,
    DirRight = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StFly  = 2'b01,
    StCool = 2'b10
  } bullet_st_e;

endpackage

// File: rtl/bullet_flight_app_if.sv
// Signal bundle between the tank controller and the bullet flight block.
interface bullet_flight_app_if;
  import bullet_flight_app_pkg::*;

  logic              enable;
  logic              step_tick;
  logic [CoordW-1:0] tank_x;
  logic [CoordW-1:0] tank_y;
  logic [1:0]        tank_dir;
  logic              bul_sht;
  logic [CoordW-1:0] tgt_x;
  logic [CoordW-1:0] tgt_y;
  logic              tgt_valid;
  logic [CoordW-1:0] bul_x;
  logic [CoordW-1:0] bul_y;
  logic [1:0]        bul_dir;
  logic              bul_state;
  logic              hit;
  logic              miss;

  modport master (
    output enable, step_tick, tank_x, tank_y, tank_dir, bul_sht, tgt_x, tgt_y, tgt_valid,
    input  bul_x, bul_y, bul_dir, bul_state, hit, miss
  );

  modport slave (
    input  enable, step_tick, tank_x, tank_y, tank_dir, bul_sht, tgt_x, tgt_y, tgt_valid,
    output bul_x, bul_y, bul_dir, bul_state, hit, miss
  );

endinterface

// File: rtl/bullet_step.sv
// Next-cell computation for one bullet step; flags the grid edge instead of wrapping.
module bullet_step
  import bullet_flight_app_pkg::*;
#(
  parameter int unsigned X_MAX = XMaxDef,
  parameter int unsigned Y_MAX = YMaxDef
) (
  input  logic [CoordW-1:0] x,
  input  logic [CoordW-1:0] y,
  input  dir_e              dir,
  output logic [CoordW-1:0] nx,
  output logic [CoordW-1:0] ny,
  output logic              at_edge
);

  always_comb begin
    nx      = x;
    ny      = y;
    at_edge = 1'b0;
    unique case (dir)
      DirUp:    if (y == '0)             at_edge = 1'b1; else ny = y - CoordW'(1);
      DirDown:  if (y == CoordW'(Y_MAX)) at_edge = 1'b1; else ny = y + CoordW'(1);
      DirLeft:  if (x == '0)             at_edge = 1'b1; else nx = x - CoordW'(1);
      DirRight: if (x == CoordW'(X_MAX)) at_edge = 1'b1; else nx = x + CoordW'(1);
      default:  at_edge = 1'b0;
    endcase
  end

endmodule

// File: rtl/bullet_flight_app.sv
// Single-bullet flight controller: launch from the tank, step across the grid, report hit/miss,
// then lock out re-fire for COOL_TICKS step ticks.
module bullet_flight_app
  import bullet_flight_app_pkg::*;
#(
  parameter int unsigned X_MAX      = XMaxDef,
  parameter int unsigned Y_MAX      = YMaxDef,
  parameter int unsigned COOL_TICKS = 4
) (
  input logic                clk,
  input logic                rst_n,
  bullet_flight_app_if.slave bus
);

  localparam int unsigned CntW = (COOL_TICKS > 1) ? $clog2(COOL_TICKS + 1) : 1;

  bullet_st_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CoordW-1:0] x_q, x_d, y_q, y_d;
  dir_e              dir_q, dir_d;
  logic              bul_state_q, bul_state_d;
  logic              hit_q, hit_d, miss_q, miss_d;

  logic [CoordW-1:0] step_x, step_y;
  logic              at_edge;
  logic              on_target;

  bullet_step #(
    .X_MAX(X_MAX),
    .Y_MAX(Y_MAX)
  ) u_step (
    .x      (x_q),
    .y      (y_q),
    .dir    (dir_q),
    .nx     (step_x),
    .ny     (step_y),
    .at_edge(at_edge)
  );

  assign on_target = bus.tgt_valid && (x_q == bus.tgt_x) && (y_q == bus.tgt_y);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    bul_state_d = bul_state_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    if (bus.enable) begin
      unique case (state_q)
        StIdle: begin
          if (bus.bul_sht) begin
            x_d         = bus.tank_x;
            y_d         = bus.tank_y;
            dir_d       = dir_e'(bus.tank_dir);
            bul_state_d = 1'b1;
            state_d     = StFly;
          end
        end
        StFly: begin
          // A target match wins over any step or edge miss in the same cycle.
          if (on_target) begin
            hit_d       = 1'b1;
            bul_state_d = 1'b0;
            cnt_d       = CntW'(COOL_TICKS);
            state_d     = StCool;
          end else if (bus.step_tick) begin
            if (at_edge) begin
              miss_d      = 1'b1;
              bul_state_d = 1'b0;
              cnt_d       = CntW'(COOL_TICKS);
              state_d     = StCool;
            end else begin
              x_d = step_x;
              y_d = step_y;
            end
          end
        end
        StCool: begin
          if (bus.step_tick) begin
            if (cnt_q <= CntW'(1)) begin
              cnt_d   = '0;
              state_d = StIdle;
            end else begin
              cnt_d = cnt_q - CntW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      dir_q       <= DirUp;
      bul_state_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      bul_state_q <= bul_state_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign bus.bul_x     = x_q;
  assign bus.bul_y     = y_q;
  assign bus.bul_dir   = dir_q;
  assign bus.bul_state = bul_state_q;
  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;

endmodule

// File: tb/tb_bullet_flight_app.sv
// Scoreboard bench for bullet_flight_app: grid-level reference model feeds an expectation queue,
// a negedge monitor pops and compares every cycle.
module tb_bullet_flight_app;
  import bullet_flight_app_pkg::*;

  localparam int XM = 24;
  localparam int YM = 12;
  localparam int CT = 4;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [1:0] dir;
    logic       st;
    logic       hit;
    logic       miss;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;

  bullet_flight_app_if bus ();

  bullet_flight_app #(
    .X_MAX     (XM),
    .Y_MAX     (YM),
    .COOL_TICKS(CT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   m_x, m_y, m_dir, m_cool;
  bit   m_fly, m_hit, m_miss;
  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic obs_t dut_obs();
    obs_t o;
    o.x    = bus.bul_x;
    o.y    = bus.bul_y;
    o.dir  = bus.bul_dir;
    o.st   = bus.bul_state;
    o.hit  = bus.hit;
    o.miss = bus.miss;
    return o;
  endfunction

  function automatic obs_t exp_obs();
    obs_t o;
    o.x    = 5'(m_x);
    o.y    = 5'(m_y);
    o.dir  = 2'(m_dir);
    o.st   = m_fly;
    o.hit  = m_hit;
    o.miss = m_miss;
    return o;
  endfunction

  function automatic void model_reset();
    m_x = 0; m_y = 0; m_dir = 0; m_cool = 0;
    m_fly = 0; m_hit = 0; m_miss = 0;
  endfunction

  // Grid-level rules: a bullet is either flying, cooling down (ticks left) or idle.
  function automatic void model_step();
    int nx, ny;
    m_hit  = 0;
    m_miss = 0;
    if (!bus.enable) return;
    if (m_fly) begin
      if (bus.tgt_valid && m_x == int'(bus.tgt_x) && m_y == int'(bus.tgt_y)) begin
        m_hit = 1; m_fly = 0; m_cool = CT;
      end else if (bus.step_tick) begin
        nx = m_x; ny = m_y;
        case (m_dir)
          0:       ny = ny - 1;
          1:       ny = ny + 1;
          2:       nx = nx - 1;
          default: nx = nx + 1;
        endcase
        if (nx < 0 || nx > XM || ny < 0 || ny > YM) begin
          m_miss = 1; m_fly = 0; m_cool = CT;
        end else begin
          m_x = nx; m_y = ny;
        end
      end
    end else if (m_cool > 0) begin
      if (bus.step_tick) m_cool = m_cool - 1;
    end else if (bus.bul_sht) begin
      m_x = int'(bus.tank_x); m_y = int'(bus.tank_y); m_dir = int'(bus.tank_dir);
      m_fly = 1;
    end
  endfunction

  always @(negedge clk) begin
    obs_t e, g;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      g = dut_obs();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t got x=%0d y=%0d dir=%0d st=%0b hit=%0b miss=%0b exp x=%0d y=%0d dir=%0d st=%0b hit=%0b miss=%0b",
                 $time, g.x, g.y, g.dir, g.st, g.hit, g.miss, e.x, e.y, e.dir, e.st, e.hit, e.miss);
      end
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    sb.push_back(exp_obs());
    #1;
  endtask

  task automatic step_pulse();
    bus.step_tick = 1'b1;
    tick();
    bus.step_tick = 1'b0;
    tick();
  endtask

  task automatic fire(input int x, input int y, input int d);
    bus.tank_x   = 5'(x);
    bus.tank_y   = 5'(y);
    bus.tank_dir = 2'(d);
    bus.bul_sht  = 1'b1;
    tick();
    bus.bul_sht  = 1'b0;
  endtask

  task automatic flush();
    bus.bul_sht   = 1'b0;
    bus.tgt_valid = 1'b0;
    bus.enable    = 1'b1;
    for (int i = 0; i < 40 && (m_fly || m_cool > 0); i++) step_pulse();
  endtask

  task automatic check_all_zero(input string tag);
    obs_t g;
    g = dut_obs();
    n_tests++;
    if (g !== '0) begin
      n_fail++;
      $display("FAIL %s got x=%0d y=%0d dir=%0d st=%0b hit=%0b miss=%0b exp all zero",
               tag, g.x, g.y, g.dir, g.st, g.hit, g.miss);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.enable    = 1'b1;
    bus.step_tick = 1'b0;
    bus.tank_x    = '0;
    bus.tank_y    = '0;
    bus.tank_dir  = '0;
    bus.bul_sht   = 1'b0;
    bus.tgt_x     = '0;
    bus.tgt_y     = '0;
    bus.tgt_valid = 1'b0;
    model_reset();
    #2;
    check_all_zero("reset_state");
    #1 rst_n = 1'b1;

    // Straight up from (5,6): walk to y=0, then miss on the next step.
    fire(5, 6, 0);
    for (int i = 0; i < 7; i++) step_pulse();
    flush();

    // Rightward shot hits target at (6,2).
    bus.tgt_x = 5'd6; bus.tgt_y = 5'd2; bus.tgt_valid = 1'b1;
    fire(3, 2, 3);
    for (int i = 0; i < 5; i++) step_pulse();
    flush();

    // Miss, then hold fire through cooldown: relaunch only after the lockout.
    fire(0, 5, 2);
    step_pulse();
    bus.bul_sht = 1'b1;
    for (int i = 0; i < 6; i++) step_pulse();
    flush();

    // Launch on the right edge: first step misses without wrapping.
    fire(24, 0, 3);
    step_pulse();
    flush();

    // Asynchronous reset mid-flight at (10,4).
    fire(10, 6, 0);
    step_pulse();
    step_pulse();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_reset_mid_fly");
    #1 rst_n = 1'b1;
    model_reset();
    fire(10, 4, 1);
    step_pulse();
    flush();

    // Freeze with enable low across several step ticks.
    fire(2, 10, 3);
    step_pulse();
    step_pulse();
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) step_pulse();
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) step_pulse();
    flush();

    // Randomized traffic, with the target often placed on the bullet's current cell.
    for (int i = 0; i < 2000; i++) begin
      bus.enable    = ($urandom_range(0, 9) != 0);
      bus.step_tick = ($urandom_range(0, 9) < 3);
      bus.bul_sht   = ($urandom_range(0, 4) == 0);
      bus.tank_x    = 5'($urandom_range(0, XM));
      bus.tank_y    = 5'($urandom_range(0, YM));
      bus.tank_dir  = 2'($urandom_range(0, 3));
      bus.tgt_valid = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        bus.tgt_x = 5'(m_x);
        bus.tgt_y = 5'(m_y);
      end else begin
        bus.tgt_x = 5'($urandom_range(0, XM));
        bus.tgt_y = 5'($urandom_range(0, YM));
      end
      tick();
    end
    bus.step_tick = 1'b0;
    flush();
    tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
